// File: rtl/mips_shift_pkg.sv
// mips_shift_pkg: opcodes and FSM state encodings shared by the serial shift unit
package mips_shift_pkg;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: shifts a word by exactly one bit position in the direction given by op
module shift_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] data_out
);
  // Reserved opcode 01 falls through to the left shift.
  always_comb
    data_out = (op == OP_SRA) ? {data_in[WIDTH-1], data_in[WIDTH-1:1]} :
               (op == OP_SRL) ? {1'b0, data_in[WIDTH-1:1]} :
                                {data_in[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/serial_shift_unit.sv
// serial_shift_unit: SLL/SRL/SRA executed one bit per clock behind a start/busy/done handshake
module serial_shift_unit
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_in (work_q),
    .op      (op_q),
    .data_out(step)
  );

  // Next state: count down while shifting, publish on zero, accept start from IDLE or DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    if (state_q == S_SHIFT) begin
      if (cnt_q == '0) begin
        state_d  = S_DONE;
        result_d = work_q;
      end else begin
        work_d = step;
        cnt_d  = cnt_q - SHW'(1);
      end
    end else if (start) begin
      state_d = S_SHIFT;
      work_d  = data_in;
      cnt_d   = shamt;
      op_d    = op;
    end else begin
      state_d = S_IDLE;
    end
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_SLL;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb_serial_shift_unit: scoreboard bench for the serial shift unit
module tb_serial_shift_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  shamt = '0;
  logic [31:0] data_in = '0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  serial_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    return (o == 2'b11) ? 32'($signed(d) >>> s) : (o == 2'b10) ? (d >> s) : (d << s);
  endfunction

  always @(negedge clk)
    if (!reset && done) begin
      if (exp_q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
      else chk("result", result, exp_q.pop_front());
    end

  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d, input bit push);
    start = 1'b1;
    op = o;
    shamt = s;
    data_in = d;
    if (push) exp_q.push_back(model(o, s, d));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    shamt = 5'($urandom);
    data_in = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic [4:0] s, input bit inj, input bit idle_after);
    int lat = 0;
    bit bad = 0;
    logic [31:0] held;
    while (!done && lat < 40) begin
      if (!busy) bad = 1;
      start = inj && lat == 1;
      if (inj && lat == 1) begin
        op = 2'b00;
        shamt = 5'd1;
        data_in = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(s) + 32'd1);
    chk({tag, "_busy_during"}, {31'd0, bad}, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (idle_after) begin
      held = result;
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_result_hold"}, result, held);
    end
  endtask

  initial begin
    bit seen;
    logic [1:0] ro;
    logic [4:0] rs;
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);

    issue(2'b00, 5'd2, 32'd65, 1); wait_done("sll65", 5'd2, 0, 1);
    issue(2'b10, 5'd2, 32'd234, 1); wait_done("srl234", 5'd2, 0, 1);
    issue(2'b11, 5'd4, 32'h8000_0000, 1); wait_done("sra_neg", 5'd4, 0, 1);
    issue(2'b11, 5'd4, 32'h7FFF_FFF0, 1); wait_done("sra_pos", 5'd4, 0, 1);
    issue(2'b10, 5'd0, 32'hDEAD_BEEF, 1); wait_done("sh0", 5'd0, 0, 1);
    issue(2'b11, 5'd31, 32'hFFFF_FFFF, 1); wait_done("sra31", 5'd31, 0, 1);
    issue(2'b00, 5'd31, 32'd1, 1); wait_done("sll31", 5'd31, 0, 1);
    issue(2'b10, 5'd4, 32'h0000_00F0, 1); wait_done("inject", 5'd4, 1, 1);
    issue(2'b00, 5'd3, 32'd3, 1); wait_done("b2b_a", 5'd3, 0, 0);
    issue(2'b11, 5'd1, 32'h8000_0010, 1); wait_done("b2b_b", 5'd1, 0, 1);
    issue(2'b01, 5'd3, 32'd5, 1); wait_done("op01", 5'd3, 0, 1);
    for (int i = 0; i < 6; i++) begin
      ro = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b10 : 2'b11;
      rs = 5'($urandom);
      rd = $urandom;
      issue(ro, rs, rd, 1);
      wait_done("rand", rs, 0, i % 2 == 1);
    end
    @(negedge clk);

    issue(2'b00, 5'd10, 32'd65, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_no_done", {31'd0, seen}, 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Multi-cycle shift unit for the MIPS datapath that executes SLL, SRL and SRA one bit position per clock. It complements the fixed left-by-2 branch-offset shifter with the other direction and variable amounts. It trades the area of a full barrel shifter for a start/busy/done handshake with the control FSM. The ALU stage issues `start` with operand, amount and opcode, then stalls until `done`.

## Interface
- `WIDTH`, default 32: datapath width.
- `SHW`, default 5: shift-amount width; must equal clog2(WIDTH).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled on the rising edge.
- `op`  in  2  shift opcode: 00 SLL, 10 SRL, 11 SRA; 01 is reserved and executes as SLL.
- `shamt`  in  SHW  shift amount, 0 to WIDTH-1.
- `data_in`  in  WIDTH  operand.
- `busy`  out  1  high while shifting.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  out  WIDTH  registered result, held until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start`: capture `data_in` into the working register, `shamt` into the counter and `op` into the op register.
  - Go to SHIFT.
- **SHIFT**
  - Counter == 0: go to DONE and copy the working register into `result`.
  - Otherwise, each cycle: shift the working register one bit and decrement the counter.
  - SLL: shift left, zero fill at bit 0.
  - SRL: shift right, zero fill at the MSB.
  - SRA: shift right, replicating the current MSB.
- **DONE**
  - `done` = 1 for this cycle only.
  - `start` in DONE is accepted exactly as in IDLE and goes to SHIFT, so back-to-back operations are allowed.
  - Otherwise return to IDLE.
- `busy` = (state == SHIFT); it is a decode of the state register.
- `start` while in SHIFT is ignored. The captured operands are unaffected and no request is queued.
- Operands are captured only when `start` is accepted. Changes on `data_in`, `shamt` or `op` afterwards have no effect.
- `result` changes only on the transition into DONE; otherwise it holds.
- Reset, including mid-operation:
  - state = IDLE, `busy` = 0, `done` = 0, `result` = 0.
  - Counter and working register cleared.
  - The in-flight operation is discarded and no `done` is produced.

## Timing
- Let `start` be accepted at rising edge k.
- `busy` is high from edge k to edge k+shamt+1.
- `done` is high for the cycle following edge k+shamt+1; `result` is valid at that edge.
- Total latency is shamt+1 cycles from the acceptance edge:
  - shamt = 0: `done` after edge k+1, `result` = `data_in`.
  - shamt = 31: `done` after edge k+32.
- Back-to-back: if `start` is high at edge k+shamt+2 (the edge that ends the DONE cycle), the next operation is accepted there and `busy` rises again.
- Worst-case throughput is one operation per shamt+2 cycles.
- There are no combinational paths from inputs to outputs.

## Structure
- Package `mips_shift_pkg` holds:
  - op localparams `OP_SLL` = 2'b00, `OP_SRL` = 2'b10, `OP_SRA` = 2'b11.
  - state encodings `S_IDLE`, `S_SHIFT`, `S_DONE`.
- One combinational sub-module, `shift_step`, takes WIDTH data and op and produces the one-bit-shifted value. The top level holds the FSM, counter, working register and result register.

## Test plan
- Reset with no `start` -> `busy` = 0, `done` = 0, `result` = 0. Assert `reset` during SHIFT of SLL 65 by 10 -> outputs return to 0 immediately and no `done` follows.
- SLL, `data_in` = 65, `shamt` = 2, `start` at edge k -> `busy` high edges k..k+3, `done` pulse after edge k+3, `result` = 260.
- SRL 234 by 2 -> `result` = 58. SRA 0x80000000 by 4 -> `result` = 0xF8000000. SRA 0x7FFFFFF0 by 4 -> `result` = 0x07FFFFFF.
- Boundaries:
  - shamt = 0 with `data_in` = 0xDEADBEEF -> `done` after edge k+1, `result` = 0xDEADBEEF.
  - SRA 0xFFFFFFFF by 31 -> 0xFFFFFFFF, `done` after edge k+32.
  - SLL 1 by 31 -> 0x80000000.
- `start` pulsed mid-SHIFT with different operands -> ignored; the original result and timing are unchanged. `start` held high in the DONE cycle -> a new operation is accepted and its result is correct. Op 01 -> behaves as SLL.
